cache_ctrl: RTL
===============

// Module: cache_ctrl
// PURPOSE
//  Sequencing controller for a 2-way set-associative, write-back, write-allocate cache model.
//  Accepts one cachepkg::inst_t command per handshake and looks up or updates tag/valid/dirty/LRU state.
//  Returns the cachepkg::output_t operation the next memory level must perform.
//  Sits between the trace/command source and the next-level bus model.
// PARAMETERS
//  ADDR_W    32  byte-address width
//  OFFSET_W  6   line-offset bits (64 B lines)
//  INDEX_W   4   set-index bits; NUM_SETS = 2**INDEX_W (16); TAG_W = ADDR_W-INDEX_W-OFFSET_W
// PORTS
//  clk            in   1       single clock, all logic on posedge
//  reset          in   1       synchronous, active-high
//  cmd_valid      in   1       command present
//  cmd_ready      out  1       controller can accept (high only in IDLE)
//  cmd_inst       in   inst_t  RESET/INVALIDATE/READ/WRITE
//  cmd_addr       in   ADDR_W  byte address
//  rsp_valid      out  1       response present; held until rsp_ready
//  rsp_ready      in   1       consumer accepts response
//  rsp_out        out  output_t READ_OUT/WRITE_OUT/RW_OUT/NOP
//  rsp_hit        out  1       tag matched a valid way
//  rsp_addr       out  ADDR_W  line fill address = {tag,index,0}; 0 unless READ_OUT/RW_OUT
//  rsp_wb_addr    out  ADDR_W  victim line address = {vtag,index,0}; 0 unless WRITE_OUT/RW_OUT
// BEHAVIOUR
//  - FSM states: CLEAR, IDLE, LOOKUP, RESP.
//  - reset: go to CLEAR with sweep counter = 0.
//    - Output reset values: cmd_ready=0, rsp_valid=0, rsp_out=NOP, rsp_hit=0, rsp_addr=0, rsp_wb_addr=0.
//    - Arrays are not reset directly; the sweep clears them.
//    - Reset in any state drops any in-flight command with no response.
//  - CLEAR: one set per cycle; valid=0, dirty=0, lru=0 for both ways. After set NUM_SETS-1 (16 cycles):
//    - if the sweep was reset-initiated, go to IDLE;
//    - if it was a RESET command, go to RESP with out=NOP, hit=0.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, capture inst/addr.
//    - RESET command goes to CLEAR; all other commands go to LOOKUP.
//  - LOOKUP (1 cycle): compare the tag against both ways, compute the result, write the arrays, go to RESP.
//    - Victim choice: first invalid way (way0 before way1), else the way pointed to by lru.
//    - READ hit: NOP, hit=1; lru := other way.
//    - WRITE hit: NOP, hit=1; set dirty; lru := other way.
//    - READ/WRITE miss, victim clean or invalid: READ_OUT.
//    - READ/WRITE miss, victim valid and dirty: RW_OUT with rsp_wb_addr = victim.
//    - On any miss, fill the victim way: valid=1, tag=new, dirty = (inst==WRITE), lru := other way.
//    - INVALIDATE hit dirty: WRITE_OUT with wb_addr = line, hit=1. INVALIDATE hit clean: NOP, hit=1.
//    - On an INVALIDATE hit, clear valid and dirty; lru := invalidated way.
//    - INVALIDATE miss: NOP, hit=0, no state change.
//  - RESP: rsp_valid=1, all rsp_* held stable. On rsp_ready go to IDLE.
//  - Latency: accept at edge T; rsp_valid is high from T+2; back-to-back throughput is 1 command per 3 cycles.
//  - cmd_inst/cmd_addr are ignored while cmd_ready=0. A tag matching both ways cannot occur.
// CONFIGURATION
//  CACHE_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_wbacks, each 32 bits.
//    - Counts are taken in LOOKUP; WRITE_OUT and RW_OUT count as wbacks.
//    - Counters saturate at 32'hFFFF_FFFF.
//    - Counters are cleared by reset and by a RESET command.
//  CACHE_STATS_EN undefined: these ports and counters do not exist.
// TESTING
//  1. Assert reset for 2 cycles, then release -> cmd_ready=0 for 16 cycles, then 1; rsp_valid stays 0 throughout.
//  2. READ 0x40 -> READ_OUT, hit=0, rsp_addr=0x40, response on T+2.
//     Then READ 0x7F -> NOP, hit=1, rsp_addr=0.
//  3. Sequence on set 1, with the following responses:
//     - WRITE 0x40 -> READ_OUT.
//     - READ 0x440 -> READ_OUT.
//     - READ 0x40 -> NOP (hit).
//     - READ 0x840 -> READ_OUT (evicts clean 0x440).
//     - READ 0x440 -> RW_OUT, rsp_addr=0x440, rsp_wb_addr=0x40.
//  4. WRITE 0x80, then INVALIDATE 0x80 -> WRITE_OUT, wb_addr=0x80, hit=1.
//     Then INVALIDATE 0x80 again -> NOP, hit=0.
//  5. Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0; the 6th-cycle rsp_ready completes.
//     Also assert reset during LOOKUP -> no response is produced and a 16-cycle CLEAR follows.
//  6. With CACHE_STATS_EN, run scenario 3 -> stat_hits=1, stat_misses=4, stat_wbacks=1.
//     Then issue a RESET command -> NOP after 16 CLEAR cycles, all stats=0, and READ 0x40 misses.

Source files
------------

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way set-associative, write-back, write-allocate cache model.
// Optional statistics counters are enabled with the CACHE_STATS_EN macro.
`timescale 1ns/1ps

package cachepkg;
    typedef enum logic [1:0] {
        RESET      = 2'd0,
        INVALIDATE = 2'd1,
        READ       = 2'd2,
        WRITE      = 2'd3
    } inst_t;

    typedef enum logic [1:0] {
        NOP       = 2'd0,
        READ_OUT  = 2'd1,
        WRITE_OUT = 2'd2,
        RW_OUT    = 2'd3
    } output_t;
endpackage

// state  | meaning
// CLEAR  | sweeping one set per cycle, clearing valid/dirty/lru
// IDLE   | cmd_ready high, waiting for a command
// LOOKUP | tag compare, result computation and array update
// RESP   | response held on rsp_* until rsp_ready
module cache_ctrl
    import cachepkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  inst_t             cmd_inst,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output output_t           rsp_out,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] rsp_wb_addr
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbacks
`endif
);
    localparam int NUM_SETS = 2 ** INDEX_W;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOOKUP, S_RESP} state_t;

    state_t state, state_nxt;

    logic [INDEX_W-1:0]        sweep;
    logic                      clear_by_cmd;
    inst_t                     inst_q;
    logic [ADDR_W-1:OFFSET_W]  line_q;

    logic [TAG_W-1:0] tag_mem [2][NUM_SETS];
    logic [1:0]       valid_mem [NUM_SETS];
    logic [1:0]       dirty_mem [NUM_SETS];
    logic [NUM_SETS-1:0] lru_mem;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         hit_vec;
    logic               any_hit, hit_way, victim, vic_dirty;
    logic [ADDR_W-1:0]  line_addr, vic_addr;
    output_t            res_out;
    logic               res_hit;
    logic [ADDR_W-1:0]  res_addr, res_wb;
    logic               accept, sweep_done;
    logic               unused_offset;

    assign unused_offset = &{1'b0, cmd_addr[OFFSET_W-1:0]};

    assign idx        = line_q[OFFSET_W +: INDEX_W];
    assign tag        = line_q[ADDR_W-1 -: TAG_W];
    assign hit_vec[0] = valid_mem[idx][0] && (tag_mem[0][idx] == tag);
    assign hit_vec[1] = valid_mem[idx][1] && (tag_mem[1][idx] == tag);
    assign any_hit    = |hit_vec;
    assign hit_way    = hit_vec[1];
    // Fill an empty way first (way0 before way1); only evict via LRU when the set is full.
    assign victim     = !valid_mem[idx][0] ? 1'b0 :
                        !valid_mem[idx][1] ? 1'b1 : lru_mem[idx];
    assign vic_dirty  = valid_mem[idx][victim] && dirty_mem[idx][victim];
    assign line_addr  = {line_q, {OFFSET_W{1'b0}}};
    assign vic_addr   = {tag_mem[victim][idx], idx, {OFFSET_W{1'b0}}};
    assign accept     = (state == S_IDLE) && cmd_valid;
    assign sweep_done = (state == S_CLEAR) && (sweep == LAST_SET);

    always_comb begin
        res_out  = NOP;
        res_hit  = 1'b0;
        res_addr = '0;
        res_wb   = '0;
        case (inst_q)
            READ, WRITE: begin
                if (any_hit) begin
                    res_hit = 1'b1;
                end else begin
                    res_addr = line_addr;
                    if (vic_dirty) begin
                        res_out = RW_OUT;
                        res_wb  = vic_addr;
                    end else begin
                        res_out = READ_OUT;
                    end
                end
            end
            INVALIDATE: begin
                if (any_hit) begin
                    res_hit = 1'b1;
                    if (dirty_mem[idx][hit_way]) begin
                        res_out = WRITE_OUT;
                        res_wb  = line_addr;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_CLEAR:  if (sweep == LAST_SET) state_nxt = clear_by_cmd ? S_RESP : S_IDLE;
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = (cmd_inst == cachepkg::RESET) ? S_CLEAR : S_LOOKUP;
            end
            S_LOOKUP: state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_CLEAR;
            sweep        <= '0;
            clear_by_cmd <= 1'b0;
            inst_q       <= READ;
            line_q       <= '0;
            rsp_out      <= NOP;
            rsp_hit      <= 1'b0;
            rsp_addr     <= '0;
            rsp_wb_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) sweep <= sweep + 1'b1;
            if (accept) begin
                inst_q       <= cmd_inst;
                line_q       <= cmd_addr[ADDR_W-1:OFFSET_W];
                clear_by_cmd <= (cmd_inst == cachepkg::RESET);
                sweep        <= '0;
            end
            if (state == S_LOOKUP) begin
                rsp_out     <= res_out;
                rsp_hit     <= res_hit;
                rsp_addr    <= res_addr;
                rsp_wb_addr <= res_wb;
            end
            if (sweep_done) begin
                rsp_out     <= NOP;
                rsp_hit     <= 1'b0;
                rsp_addr    <= '0;
                rsp_wb_addr <= '0;
            end
        end
    end

    // Tag/state arrays carry no reset; the CLEAR sweep initialises them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                valid_mem[sweep] <= 2'b00;
                dirty_mem[sweep] <= 2'b00;
                lru_mem[sweep]   <= 1'b0;
            end else if (state == S_LOOKUP) begin
                if (inst_q == READ || inst_q == WRITE) begin
                    if (any_hit) begin
                        if (inst_q == WRITE) dirty_mem[idx][hit_way] <= 1'b1;
                        lru_mem[idx] <= ~hit_way;
                    end else begin
                        valid_mem[idx][victim] <= 1'b1;
                        tag_mem[victim][idx]   <= tag;
                        dirty_mem[idx][victim] <= (inst_q == WRITE);
                        lru_mem[idx]           <= ~victim;
                    end
                end else if (inst_q == INVALIDATE && any_hit) begin
                    valid_mem[idx][hit_way] <= 1'b0;
                    dirty_mem[idx][hit_way] <= 1'b0;
                    lru_mem[idx]            <= hit_way;
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || (accept && cmd_inst == cachepkg::RESET)) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
        end else if (state == S_LOOKUP) begin
            if (any_hit) stat_hits   <= sat_inc(stat_hits);
            else         stat_misses <= sat_inc(stat_misses);
            if (res_out == WRITE_OUT || res_out == RW_OUT) stat_wbacks <= sat_inc(stat_wbacks);
        end
    end
`endif

endmodule
